// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] PC_INC      = 16'd2;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED
  } fetch_state_e;

  // True when the instruction's opcode field matches the HALT opcode.
  function automatic logic is_halt(input logic [15:0] instr,
                                   input logic [4:0]  halt_op);
    return instr[15:11] == halt_op;
  endfunction

endpackage

// File: rtl/fetch_redirect_tracker.sv
// Remembers a redirect that arrives while an imem access is in flight,
// so it can be applied when that access finally completes.
module fetch_redirect_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [15:0] redirect_pc_x,
  output logic        redirect_pending,
  output logic [15:0] redirect_pc_q
);

  // A newer redirect overwrites an older one; delivery clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pending <= 1'b0;
      redirect_pc_q    <= '0;
    end else if (capture) begin
      redirect_pending <= 1'b1;
      redirect_pc_q    <= redirect_pc_x;
    end else if (clear) begin
      redirect_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/register_we.sv
// Generic register with synchronous active-high reset and write enable.
module register_we #(
  parameter int            W         = 16,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load reset value, otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst)
      q <= RESET_VAL;
    else if (write_en)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the multicycle imem handshake
// and feeds the fetch/decode latch with instruction, PC+2 and bubble flag.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = fetch_pkg::NOP_INSTR,
  parameter logic [4:0]  HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_f,
  input  logic        redirect_x,
  input  logic [15:0] redirect_pc_x,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instr_f,
  output logic [15:0] pc_plus2_f,
  output logic        nop_f,
  output logic        halted
);

  import fetch_pkg::*;

  fetch_state_e state, state_next;

  logic [15:0] pc, pc_next, pc_plus2;
  logic        pc_we;
  logic [15:0] buf_instr;
  logic        buf_we;
  logic        redirect_pending;
  logic [15:0] redirect_pc_q;
  logic        in_flight, delivering, squash_now;

  assign pc_plus2   = pc + PC_INC;  // 16-bit modulo, FFFE wraps to 0000
  assign in_flight  = (state == ST_FETCH) || (state == ST_WAIT);
  assign delivering = in_flight && imem_done;
  assign squash_now = redirect_x || redirect_pending;

  register_we #(.W(16), .RESET_VAL(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .write_en (pc_we),
    .d        (pc_next),
    .q        (pc)
  );

  // NOTE: the hold buffer is reset to a NOP so its contents are never X,
  // even though it is only read in HOLD after being written.
  register_we #(.W(16), .RESET_VAL(NOP_INSTR)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .write_en (buf_we),
    .d        (imem_data),
    .q        (buf_instr)
  );

  fetch_redirect_tracker u_redirect (
    .clk              (clk),
    .rst              (rst),
    .capture          (in_flight && !imem_done && redirect_x),
    .clear            (delivering),
    .redirect_pc_x    (redirect_pc_x),
    .redirect_pending (redirect_pending),
    .redirect_pc_q    (redirect_pc_q)
  );

  // Next state, PC update and buffer capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    pc_we      = 1'b0;
    pc_next    = pc_plus2;
    buf_we     = 1'b0;
    case (state)
      ST_FETCH, ST_WAIT: begin
        if (!imem_done) begin
          state_next = ST_WAIT;
        end else if (squash_now) begin
          pc_we      = 1'b1;
          pc_next    = redirect_x ? redirect_pc_x : redirect_pc_q;
          state_next = ST_FETCH;
        end else if (hold_f) begin
          buf_we     = 1'b1;
          state_next = ST_HOLD;
        end else if (is_halt(imem_data, HALT_OPCODE)) begin
          state_next = ST_HALTED;
        end else begin
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_x) begin
          pc_we      = 1'b1;
          pc_next    = redirect_pc_x;
          state_next = ST_FETCH;
        end else if (!hold_f) begin
          if (is_halt(buf_instr, HALT_OPCODE)) begin
            state_next = ST_HALTED;
          end else begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        if (redirect_x) begin
          pc_we      = 1'b1;
          pc_next    = redirect_pc_x;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_FETCH;
    else
      state <= state_next;
  end

  // Outputs to imem and the fetch/decode latch.
  always_comb begin
    imem_rd    = !rst && (state == ST_FETCH);
    imem_addr  = pc;
    halted     = !rst && (state == ST_HALTED);
    pc_plus2_f = pc_plus2;
    nop_f      = 1'b1;
    if (!rst) begin
      case (state)
        ST_FETCH, ST_WAIT: nop_f = !(imem_done && !squash_now);
        ST_HOLD:           nop_f = redirect_x;
        default:           nop_f = 1'b1;
      endcase
    end
    if (nop_f)
      instr_f = NOP_INSTR;
    else if (state == ST_HOLD)
      instr_f = buf_instr;
    else
      instr_f = imem_data;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a scoreboard of delivered
// instructions checked by an independent monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_f = 1'b0;
  logic        redirect_x = 1'b0;
  logic [15:0] redirect_pc_x = '0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        imem_done = 1'b0;
  logic [15:0] instr_f;
  logic [15:0] pc_plus2_f;
  logic        nop_f;
  logic        halted;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .hold_f        (hold_f),
    .redirect_x    (redirect_x),
    .redirect_pc_x (redirect_pc_x),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_done     (imem_done),
    .instr_f       (instr_f),
    .pc_plus2_f    (pc_plus2_f),
    .nop_f         (nop_f),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, return at the
  // following falling edge so outputs can be sampled.
  task automatic cyc_r(input logic r, input logic done, input logic [15:0] data,
                       input logic hold, input logic redir, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    rst           = r;
    imem_done     = done;
    imem_data     = data;
    hold_f        = hold;
    redirect_x    = redir;
    redirect_pc_x = rpc;
    @(negedge clk);
  endtask

  task automatic step(input logic done, input logic [15:0] data,
                      input logic hold, input logic redir, input logic [15:0] rpc);
    cyc_r(1'b0, done, data, hold, redir, rpc);
  endtask

  task automatic expect_deliv(input logic [15:0] instr, input logic [15:0] pcp2);
    exp_t e;
    e.instr = instr;
    e.pcp2  = pcp2;
    sb.push_back(e);
  endtask

  // Monitor: every advancing (non-bubble, non-held) output is compared
  // against the oldest expected delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && nop_f === 1'b0 && hold_f === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_deliv: got instr %h with nothing expected", instr_f);
        end else begin
          mon_e = sb.pop_front();
          check("deliv_instr", instr_f, mon_e.instr);
          check("deliv_pcp2", pc_plus2_f, mon_e.pcp2);
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc_r(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("rst_imem_rd", {15'b0, imem_rd}, 16'd0);
    check("rst_nop", {15'b0, nop_f}, 16'd1);
    check("rst_instr", instr_f, 16'h0800);
    check("rst_halted", {15'b0, halted}, 16'd0);

    // 0-wait memory from reset
    expect_deliv(16'h1111, 16'h0002);
    step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
    check("hit0_addr", imem_addr, 16'h0000);
    check("hit0_rd", {15'b0, imem_rd}, 16'd1);
    check("hit0_nop", {15'b0, nop_f}, 16'd0);
    expect_deliv(16'h2222, 16'h0004);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
    check("hit1_addr", imem_addr, 16'h0002);

    // Redirect to 0x0010 on a hit: squashed
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h0010);
    check("sq1_nop", {15'b0, nop_f}, 16'd1);

    // 3-cycle latency at 0x0010
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("lat_f_rd", {15'b0, imem_rd}, 16'd1);
    check("lat_f_addr", imem_addr, 16'h0010);
    check("lat_f_nop", {15'b0, nop_f}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      check("lat_w_rd", {15'b0, imem_rd}, 16'd0);
      check("lat_w_addr", imem_addr, 16'h0010);
      check("lat_w_nop", {15'b0, nop_f}, 16'd1);
    end
    expect_deliv(16'h3333, 16'h0012);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0000);
    check("lat_d_rd", {15'b0, imem_rd}, 16'd0);
    expect_deliv(16'h4444, 16'h0014);
    step(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0000);
    check("lat_next_addr", imem_addr, 16'h0012);
    check("lat_next_rd", {15'b0, imem_rd}, 16'd1);

    // Redirect during WAIT at 0x0020 to 0x0040
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h0020);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("rw_f_addr", imem_addr, 16'h0020);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040);
    check("rw_w_addr", imem_addr, 16'h0020);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    check("rw_w2_addr", imem_addr, 16'h0020);
    step(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000);
    check("rw_d_nop", {15'b0, nop_f}, 16'd1);

    // Hold for 3 cycles at delivery of 0x1234 from 0x0040
    expect_deliv(16'h1234, 16'h0042);
    step(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000);
    check("rw_next_addr", imem_addr, 16'h0040);
    check("hold_d_instr", instr_f, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'hBBBB, 1'b1, 1'b0, 16'h0000);
      check("hold_instr", instr_f, 16'h1234);
      check("hold_rd", {15'b0, imem_rd}, 16'd0);
      check("hold_nop", {15'b0, nop_f}, 16'd0);
    end
    step(1'b0, 16'hBBBB, 1'b0, 1'b0, 16'h0000);
    check("hold_rel_rd", {15'b0, imem_rd}, 16'd0);
    // Redirect to 0x0008 on the next hit; confirm pc advanced exactly once
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h0008);
    check("hold_after_addr", imem_addr, 16'h0042);

    // HALT at 0x0008
    expect_deliv(16'h0000, 16'h000A);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("halt_addr", imem_addr, 16'h0008);
    check("halt_nop", {15'b0, nop_f}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      check("halted_flag", {15'b0, halted}, 16'd1);
      check("halted_rd", {15'b0, imem_rd}, 16'd0);
      check("halted_nop", {15'b0, nop_f}, 16'd1);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
    check("halt_redir_nop", {15'b0, nop_f}, 16'd1);
    expect_deliv(16'h6666, 16'h0102);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 16'h0000);
    check("resume_halted", {15'b0, halted}, 16'd0);
    check("resume_addr", imem_addr, 16'h0100);
    check("resume_rd", {15'b0, imem_rd}, 16'd1);

    // Redirect coincident with a hit at 0xFFFE
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 16'h0200);
    check("wrap_sq_addr", imem_addr, 16'hFFFE);
    check("wrap_sq_nop", {15'b0, nop_f}, 16'd1);
    check("wrap_sq_pcp2", pc_plus2_f, 16'h0000);
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'hFFFE);
    check("wrap_tgt_addr", imem_addr, 16'h0200);

    // Unredirected delivery at 0xFFFE wraps to 0x0000
    expect_deliv(16'h7777, 16'h0000);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("wrap_addr", imem_addr, 16'h0000);

    // Reset mid-WAIT abandons the access
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    cyc_r(1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000);
    check("rstw_nop", {15'b0, nop_f}, 16'd1);
    check("rstw_rd", {15'b0, imem_rd}, 16'd0);
    expect_deliv(16'h8888, 16'h0002);
    step(1'b1, 16'h8888, 1'b0, 1'b0, 16'h0000);
    check("rstw_addr", imem_addr, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("rstw_next_addr", imem_addr, 16'h0002);

    check("sb_empty", sb.size()[15:0], 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the PC and drives a multicycle instruction-memory handshake. It produces the instruction, PC+2 and a bubble flag for the fetch/decode pipeline latch. It absorbs memory latency, hazard holds, branch/jump redirects from execute, and HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, encoding emitted when the stage has no valid instruction.
HALT_OPCODE, 5'b00000, instr[15:11] value that stops fetching.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
hold_f  in  1  hazard-unit stall; the delivered instruction must not advance.
redirect_x  in  1  taken branch/jump resolved in execute; squash fetch.
redirect_pc_x  in  16  redirect target.
imem_rd  out  1  read request, asserted only in FETCH.
imem_addr  out  16  fetch address, stable from FETCH through the end of WAIT.
imem_data  in  16  returned instruction, valid when imem_done=1.
imem_done  in  1  read complete (may be same cycle as imem_rd on a hit).
instr_f  out  16  instruction to FD latch (NOP_INSTR when nop_f=1).
pc_plus2_f  out  16  PC+2 of instr_f.
nop_f  out  1  bubble into FD latch.
halted  out  1  stage is in HALTED.

Behaviour:
- States: FETCH, WAIT, HOLD, HALTED. A 1-entry instruction buffer (buf_instr) is used in HOLD. redirect_pending and redirect_pc_q are registered.
- Reset, applied in the cycle rst=1:
  - next state FETCH; pc=RESET_PC; buffer empty; redirect_pending=0.
  - Outputs during rst: imem_rd=0, nop_f=1, instr_f=NOP_INSTR, halted=0.
- FETCH:
  - imem_rd=1, imem_addr=pc.
  - imem_done=0: go to WAIT.
  - imem_done=1: deliver in the same cycle (0-wait hit), applying the delivery rules below.
- WAIT:
  - imem_rd=0, imem_addr=pc, nop_f=1.
  - Stay in WAIT until imem_done=1, then deliver.
  - redirect_x in WAIT: set redirect_pending=1 and redirect_pc_q=redirect_pc_x. A later redirect overwrites the earlier one. pc must not change while the access is in flight.
- Delivery cycle, evaluated in priority order:
  1. redirect_x or redirect_pending: nop_f=1 (squash); pc<=redirect target (redirect_x value wins over pending); clear pending; go to FETCH.
  2. hold_f=1: nop_f=0, instr_f=imem_data; capture into buf_instr; go to HOLD; pc unchanged.
  3. Opcode==HALT_OPCODE: nop_f=0 (HALT passes to decode); pc unchanged; go to HALTED.
  4. Otherwise: nop_f=0, instr_f=imem_data, pc_plus2_f=pc+2; pc<=pc+2; go to FETCH.
- HOLD:
  - imem_rd=0, instr_f=buf_instr, nop_f=0.
  - redirect_x: drop buffer, nop_f=1, pc<=redirect_pc_x, go to FETCH.
  - Else, on hold_f=0: the buffered instruction is consumed this cycle, then apply rule 3 or 4 (HALT goes to HALTED; otherwise pc<=pc+2 and go to FETCH).
- HALTED:
  - imem_rd=0, nop_f=1, halted=1; pc frozen.
  - redirect_x (HALT was on a wrong path): pc<=redirect_pc_x, go to FETCH, halted=0 next cycle.
- Arithmetic: PC math is 16-bit modulo. 16'hFFFE+2 wraps to 16'h0000 with no flag.
- pc_plus2_f is always pc+2 of the current pc; the FD latch ignores it when nop_f=1.
- hold_f outside a delivery cycle has no effect on state. The FD latch is frozen externally.
- rst mid-WAIT abandons the access. Any late imem_done for that access must be ignored; the memory contract is that it is reset on the same rst.

Decomposition:
- Shared pipeline package holds: NOP_INSTR, HALT_OPCODE, the fetch state enum, and the PC-increment constant (2).
- The PC and buffer use the codebase's existing register module (writeEn form).
- One natural sub-module: fetch_redirect_tracker, which holds redirect_pending and redirect_pc_q with its overwrite/clear rules.

Test Plan:
- Reset then 0-wait memory, instrs at 0x0000/0x0002: 1 cycle after rst deasserts, imem_addr=0x0000, nop_f=0, pc_plus2_f=0x0002; next cycle imem_addr=0x0002.
- 3-cycle memory latency at pc=0x0010: imem_rd=1 for one cycle; nop_f=1 for 2 WAIT cycles; instruction delivered on done; next request at 0x0012.
- redirect_x to 0x0040 during WAIT at 0x0020: delivery cycle nop_f=1; next imem_addr=0x0040, never 0x0022.
- hold_f=1 for 3 cycles at delivery of 0x1234: instr_f stays 0x1234, no imem_rd; after release pc advances by 2 exactly once.
- HALT (0x0000) fetched at 0x0008: nop_f=0 that cycle, then halted=1 and imem_rd=0 indefinitely. redirect_x to 0x0100 then resumes fetch at 0x0100.
- redirect_x coincident with 0-wait imem_done at 0xFFFE: squashed (nop_f=1), pc=target. Separately, an unredirected delivery at 0xFFFE wraps pc to 0x0000.
